// File: rtl/bus_copy_master_if.sv
`default_nettype none
// ============================================================================
// Module   : master_bus_if
// Purpose  : Shared memory bus between one initiator and one memory/peripheral.
// Revision : 1.0
// ============================================================================
interface master_bus_if;
    logic        bstart;
    logic        ttype;    // 0 = READ, 1 = WRITE
    logic [1:0]  tsize;    // 0 = BYTE, 1 = HALF, 2 = WORD
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;

    modport master (
        output bstart, ttype, tsize, addr, wdata,
        input  rdata, bdone
    );

    modport slave (
        input  bstart, ttype, tsize, addr, wdata,
        output rdata, bdone
    );
endinterface
`default_nettype wire

// File: rtl/bus_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : bus_copy_master
// Purpose  : Bus initiator copying a block of 32-bit words, one read then one
//            write per word, with alignment check and optional bdone timeout.
// Revision : 1.0
// ============================================================================
module bus_copy_master #(
    parameter int LEN_W    = 16,
    parameter int MAX_WAIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    master_bus_if.master     bus,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code
);
    localparam logic       c_read        = 1'b0;
    localparam logic       c_write       = 1'b1;
    localparam logic [1:0] c_size_word   = 2'd2;
    localparam logic [1:0] c_err_none    = 2'd0;
    localparam logic [1:0] c_err_align   = 2'd1;
    localparam logic [1:0] c_err_timeout = 2'd2;
    localparam int         c_wait_w      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FIN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_src;
    logic [31:0]         r_dst;
    logic [LEN_W-1:0]    r_rem;
    logic [31:0]         r_addr;
    logic                r_ttype;
    logic [31:0]         r_data;
    logic [c_wait_w-1:0] r_wait;
    logic [1:0]          r_err_code;
    logic                w_misalign;
    logic                w_active;
    logic                w_timeout;

    assign w_misalign = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
    assign w_active   = (r_state == S_RD) || (r_state == S_WR);
    // Expires on the MAX_WAIT-th consecutive cycle without bdone.
    assign w_timeout  = (MAX_WAIT > 0) && w_active && !bus.bdone && (r_wait == c_wait_last);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_misalign)
                        w_next = S_ERR;
                    else if (len == '0)
                        w_next = S_FIN;
                    else
                        w_next = S_RD;
                end
            end
            S_RD: begin
                if (bus.bdone)
                    w_next = S_WR;
                else if (w_timeout)
                    w_next = S_ERR;
            end
            S_WR: begin
                if (bus.bdone)
                    w_next = (r_rem == LEN_W'(1)) ? S_FIN : S_RD;
                else if (w_timeout)
                    w_next = S_ERR;
            end
            S_FIN:   w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_rem      <= '0;
            r_addr     <= '0;
            r_ttype    <= c_read;
            r_data     <= '0;
            r_wait     <= '0;
            r_err_code <= c_err_none;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_active && !bus.bdone)
                r_wait <= r_wait + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src      <= src_addr;
                        r_dst      <= dst_addr;
                        r_rem      <= len;
                        r_err_code <= w_misalign ? c_err_align : c_err_none;
                        if (w_next == S_RD) begin
                            r_addr  <= src_addr;
                            r_ttype <= c_read;
                        end
                    end
                end
                S_RD: begin
                    if (bus.bdone) begin
                        r_data  <= bus.rdata;
                        r_addr  <= r_dst;
                        r_ttype <= c_write;
                    end else if (w_timeout) begin
                        r_err_code <= c_err_timeout;
                    end
                end
                S_WR: begin
                    if (bus.bdone) begin
                        r_src   <= r_src + 32'd4;
                        r_dst   <= r_dst + 32'd4;
                        r_rem   <= r_rem - LEN_W'(1);
                        r_addr  <= r_src + 32'd4;
                        r_ttype <= c_read;
                    end else if (w_timeout) begin
                        r_err_code <= c_err_timeout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bstart = w_active;
    assign bus.ttype  = r_ttype;
    assign bus.tsize  = c_size_word;
    assign bus.addr   = r_addr;
    assign bus.wdata  = r_data;
    assign busy       = w_active;
    assign done       = (r_state == S_FIN);
    assign error      = (r_state == S_ERR);
    assign err_code   = r_err_code;
endmodule
`default_nettype wire

// File: tb/tb_bus_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_copy_master
// Purpose  : Randomized self-checking bench: word-level copy model vs. DUT.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bus_copy_master;
    localparam int LEN_W = 16;
    localparam int MW_A  = 8;
    localparam int MW_B  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_a = 1'b0;
    logic             start_b = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy_a, done_a, error_a;
    logic             busy_b, done_b, error_b;
    logic [1:0]       code_a, code_b;

    always #5 clk = ~clk;

    master_bus_if bus_a();
    master_bus_if bus_b();

    bus_copy_master #(.LEN_W(LEN_W), .MAX_WAIT(MW_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .start(start_a),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy_a), .done(done_a), .error(error_a), .err_code(code_a)
    );

    bus_copy_master #(.LEN_W(LEN_W), .MAX_WAIT(MW_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .start(start_b),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy_b), .done(done_b), .error(error_b), .err_code(code_b)
    );

    function automatic logic [31:0] seed_word(input int i);
        return 32'h5A3C_0000 ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    // Memory slave for DUT A: 256 words, aliased on addr[9:2].
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = seed_word(i);
        forever begin
            @(posedge clk);
            if (rst_n && bus_a.bstart && bus_a.bdone && bus_a.ttype)
                mem[bus_a.addr[9:2]] = bus_a.wdata;
        end
    end
    assign bus_a.rdata = mem[bus_a.addr[9:2]];
    assign bus_b.rdata = 32'hCAFE_0001;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus-owned requests to the checker.
    int          mode = 0;
    int          lat_exp = -1;
    int          req_id = 0;
    int          req_kind = 0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    int          req_n = 0;

    // Checker / model state.
    typedef struct packed { logic wr; logic [31:0] addr; } xfer_t;
    xfer_t       q[$];
    xfer_t       hd;
    logic [31:0] mmem [0:255];
    logic [31:0] mdata = '0;
    logic [31:0] ta, tb_addr;
    logic        exp_done = 0, exp_err = 0, nxt_done = 0, nxt_err = 0;
    logic [1:0]  exp_code = 0;
    int          mwait = 0, rd_cnt = 0, stall_cnt = 0, cur_mode = 0;
    int          start_cyc = 0, lat_cur = -1, b_n = 0, handled_req = 0, nbad = 0;
    int          checks = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mmem[i] = seed_word(i);
        bus_a.bdone = 1'b1;
        bus_b.bdone = 1'b1;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                q.delete();
                exp_done = 0; exp_err = 0; nxt_done = 0; nxt_err = 0;
                exp_code = 0; lat_cur = -1; b_n = 0;
                chk("rst_bstart", bus_a.bstart, 0);
                chk("rst_busy", busy_a, 0);
                chk("rst_done", done_a, 0);
                chk("rst_error", error_a, 0);
                chk("rst_err_code", code_a, 0);
                chk("rst_addr", bus_a.addr, 0);
                chk("rst_wdata", bus_a.wdata, 0);
                chk("rst_ttype", bus_a.ttype, 0);
                chk("rst_tsize", bus_a.tsize, 2);
                chk("rst_b_bstart", bus_b.bstart, 0);
            end else begin
                exp_done = nxt_done; exp_err = nxt_err;
                nxt_done = 0; nxt_err = 0;
                if (start_a) begin
                    start_cyc = cyc - 1; lat_cur = lat_exp; cur_mode = mode;
                    rd_cnt = 0; stall_cnt = 0; mwait = 0;
                    if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
                        exp_err = 1; exp_code = 1;
                    end else begin
                        exp_code = 0;
                        if (len == 0) exp_done = 1;
                        for (int k = 0; k < int'(len); k++) begin
                            q.push_back({1'b0, src_addr + 32'(4 * k)});
                            q.push_back({1'b1, dst_addr + 32'(4 * k)});
                        end
                    end
                end
                // Slave ready decision for this cycle.
                bus_a.bdone = 1'b1;
                if (q.size() != 0) begin
                    if (cur_mode == 1)
                        bus_a.bdone = ($urandom_range(0, 3) != 0);
                    else if (cur_mode == 2 && !q[0].wr && rd_cnt == 1 && stall_cnt < 3) begin
                        bus_a.bdone = 1'b0;
                        stall_cnt++;
                    end
                end
                chk("a_bstart", bus_a.bstart, q.size() != 0);
                chk("a_busy", busy_a, q.size() != 0);
                chk("a_done", done_a, exp_done);
                chk("a_error", error_a, exp_err);
                chk("a_err_code", code_a, exp_code);
                if (q.size() != 0) begin
                    chk("a_addr", bus_a.addr, q[0].addr);
                    chk("a_ttype", bus_a.ttype, q[0].wr);
                    chk("a_tsize", bus_a.tsize, 2);
                    if (q[0].wr) chk("a_wdata", bus_a.wdata, mdata);
                end
                if (done_a && lat_cur >= 0) begin
                    chk("a_latency", cyc - start_cyc, lat_cur);
                    lat_cur = -1;
                end
                if (q.size() != 0) begin
                    if (bus_a.bdone) begin
                        hd = q.pop_front();
                        if (!hd.wr) begin
                            mdata = mmem[hd.addr[9:2]];
                            rd_cnt++;
                        end else begin
                            mmem[hd.addr[9:2]] = mdata;
                        end
                        mwait = 0;
                        if (q.size() == 0) nxt_done = 1;
                    end else begin
                        mwait++;
                        if (mwait == MW_A) begin
                            q.delete(); nxt_err = 1; exp_code = 2;
                        end
                    end
                end

                // DUT B: hand-computed timeline, MAX_WAIT=2, second read stalled.
                if (start_b) b_n = 1;
                else if (b_n != 0) b_n = (b_n == 6) ? 0 : b_n + 1;
                bus_b.bdone = !(b_n >= 3 && b_n <= 5);
                case (b_n)
                    0: chk("b_idle_bstart", bus_b.bstart, 0);
                    1: begin
                        chk("b_rd0_bstart", bus_b.bstart, 1);
                        chk("b_rd0_addr", bus_b.addr, 32'h40);
                        chk("b_rd0_ttype", bus_b.ttype, 0);
                        chk("b_rd0_busy", busy_b, 1);
                    end
                    2: begin
                        chk("b_wr0_addr", bus_b.addr, 32'h80);
                        chk("b_wr0_ttype", bus_b.ttype, 1);
                        chk("b_wr0_wdata", bus_b.wdata, 32'hCAFE_0001);
                    end
                    3, 4: begin
                        chk("b_stall_bstart", bus_b.bstart, 1);
                        chk("b_stall_addr", bus_b.addr, 32'h44);
                        chk("b_stall_ttype", bus_b.ttype, 0);
                    end
                    5: begin
                        chk("b_to_bstart", bus_b.bstart, 0);
                        chk("b_to_busy", busy_b, 0);
                        chk("b_to_error", error_b, 1);
                        chk("b_to_code", code_b, 2);
                        chk("b_to_done", done_b, 0);
                    end
                    default: begin
                        chk("b_after_error", error_b, 0);
                        chk("b_after_code", code_b, 2);
                    end
                endcase

                if (req_id != handled_req) begin
                    handled_req = req_id;
                    if (req_kind == 1) begin
                        nbad = 0;
                        for (int i = 0; i < 256; i++) if (mem[i] !== mmem[i]) nbad++;
                        chk("mem_image_bad_words", nbad, 0);
                    end else begin
                        for (int k = 0; k < req_n; k++) begin
                            ta      = req_a + 32'(4 * k);
                            tb_addr = req_b + 32'(4 * k);
                            if (req_kind == 3)
                                chk("copy_word_seed", mem[tb_addr[9:2]], seed_word(int'(ta[9:2])));
                            else
                                chk("copy_word_src", mem[tb_addr[9:2]], mem[ta[9:2]]);
                        end
                    end
                end
            end
        end
    end

    task automatic copy(input logic [31:0] s, input logic [31:0] d, input int n,
                        input int m, input int lat);
        @(negedge clk); #1;
        src_addr = s; dst_addr = d; len = LEN_W'(n); mode = m; lat_exp = lat;
        start_a = 1'b1;
        @(negedge clk); #1;
        start_a  = 1'b0;
        src_addr = $urandom; dst_addr = $urandom; len = LEN_W'($urandom);
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0 && !nxt_done && !nxt_err) break;
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
    endtask

    task automatic mem_req(input int k, input logic [31:0] a, input logic [31:0] b, input int n);
        @(negedge clk); #1;
        req_kind = k; req_a = a; req_b = b; req_n = n;
        req_id++;
        @(negedge clk); #1;
    endtask

    initial begin
        logic [31:0] s, d;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;

        copy(32'h100, 32'h200, 4, 0, 9);
        mem_req(3, 32'h100, 32'h200, 4);
        copy(32'h300, 32'h380, 0, 0, 1);
        copy(32'h102, 32'h200, 3, 0, -1);
        copy(32'h10, 32'h20, 1, 0, 3);
        copy(32'h10, 32'h21, 2, 0, -1);
        copy(32'h400, 32'h600, 4, 2, 12);

        @(negedge clk); #1;
        src_addr = 32'h40; dst_addr = 32'h80; len = LEN_W'(2); start_b = 1'b1;
        @(negedge clk); #1;
        start_b = 1'b0;
        repeat (7) @(negedge clk);
        #1;

        for (int t = 0; t < 24; t++) begin
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) s[1:0] = 2'($urandom_range(1, 3));
            copy(s, d, $urandom_range(0, 6), 1, -1);
        end
        mem_req(1, 0, 0, 0);

        // Asynchronous reset while the second word's write is on the bus.
        @(negedge clk); #1;
        src_addr = 32'h700; dst_addr = 32'h800; len = LEN_W'(5); mode = 0; lat_exp = -1;
        start_a = 1'b1;
        @(negedge clk); #1;
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        copy(32'hFFFF_FFFC, 32'h900, 2, 0, 5);
        mem_req(2, 32'hFFFF_FFFC, 32'h900, 2);
        mem_req(1, 0, 0, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- Initiator-side engine on the shared memory bus; drives a `master_bus_if.master` port into the slave side of a memory or peripheral.
- Copies a block of 32-bit words from a source address to a destination address.
- Each word is one READ transfer followed by one WRITE transfer.
- Software, or a test controller, programs the source, destination and length, then pulses start. The block then reports busy, done and error.

Parameters:
- LEN_W, 16, width of the word-count input.
- MAX_WAIT, 0, cycles to wait for bdone before aborting the transfer with a timeout error. 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus  interface  master_bus_if.master  bus initiator port:
  - Drives: bstart (1), ttype (READ/WRITE), tsize (fixed WORD), addr (32), wdata (32).
  - Samples: rdata (32), bdone (1).
- start  input  1  single-cycle request; sampled only in IDLE.
- src_addr  input  32  first source byte address; must be 4-byte aligned.
- dst_addr  input  32  first destination byte address; must be 4-byte aligned.
- len  input  LEN_W  number of words to copy.
- busy  output  1  high from the cycle after start is accepted until done or error is pulsed.
- done  output  1  single-cycle pulse when the copy completes successfully.
- error  output  1  single-cycle pulse on misalignment or timeout.
- err_code  output  2  0 = none, 1 = misaligned, 2 = timeout. Held until the next accepted start.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - bstart, busy, done and error go to 0; err_code goes to 0.
  - addr and wdata go to 0; ttype goes to READ; tsize goes to WORD.
  - Reset mid-transfer abandons the transfer immediately; nothing is retried.
- States: IDLE, RD, WR, FIN, ERR.
- IDLE:
  - On start, latch src, dst and len, and clear err_code.
  - If src[1:0] or dst[1:0] is nonzero, go to ERR with code 1.
  - Else if len == 0, go to FIN.
  - Else go to RD.
  - start while not in IDLE is ignored.
- Bus handshake:
  - Rule: while in RD or WR, bstart = 1 and addr, ttype, tsize and wdata are held stable. The transfer completes on the rising edge where bstart && bdone.
  - The slave may hold bdone permanently high. Single-cycle completion is the normal case.
  - bstart is 0 in IDLE, FIN and ERR.
- RD:
  - ttype = READ, addr = src pointer.
  - On completion, capture rdata into the data register and go to WR.
- WR:
  - ttype = WRITE, addr = dst pointer, wdata = data register.
  - On completion: src += 4, dst += 4, remaining -= 1.
  - If remaining becomes 0, go to FIN; else go to RD.
- Address arithmetic: 32-bit modulo. 0xFFFFFFFC + 4 wraps to 0x00000000 without error.
- FIN: done = 1 for exactly one cycle, busy = 0 in that cycle, next state IDLE.
- ERR: error = 1 for exactly one cycle, busy = 0, next state IDLE. err_code is held.
- Timeout (MAX_WAIT > 0):
  - A wait counter clears on entry to RD/WR and increments each cycle that bdone = 0.
  - When it reaches MAX_WAIT without completion, go to ERR with code 2. bstart drops the next cycle.
- Latency with bdone tied high:
  - start accepted at edge 0.
  - Word k read completes at edge 2k+1; its write completes at edge 2k+2.
  - done is high in the cycle after edge 2·len.
  - Total: 2·len+1 cycles from start to done pulse.
  - len = 0 gives done in the cycle after the start edge.
- len latched at start; changes to inputs during busy have no effect.
- Only full-word transfers are issued; byte and halfword are never driven.

Test Plan:
- Copy 4 words from src=0x100 to dst=0x200 against the memory slave with bdone high. Expect:
  - Bus sequence R100, W200, R104, W204, ..., W20C.
  - Memory at 0x200..0x20C equals the source contents.
  - done pulse exactly 9 cycles after start.
- len=0, start → no bstart ever asserted; done one cycle after start; err_code=0.
- src=0x102, len=3 → no bus activity; one-cycle error pulse with err_code=1; next start with aligned addresses succeeds and clears err_code.
- Slave stalls bdone low for 3 cycles on the second read, MAX_WAIT=8. Expect:
  - addr/ttype held stable throughout the stall.
  - Copy completes correctly; done delayed by 3 cycles.
- Same stall with MAX_WAIT=2 → error with err_code=2; bstart low the cycle after; busy low.
- Pulse rst_n low during a WR of a 5-word copy → bstart, busy and done go to 0 asynchronously. After release, state is IDLE and a fresh 2-word copy with src=0xFFFFFFFC verifies wrap to 0x0.
